temp_bcd_conv: RTL and testbench

Converts a raw DS18B20 temperature word into sign-magnitude BCD digits for the seven-segment display path. It sits between the sensor controller, whose 16-bit two's-complement reading and 2-bit resolution code it consumes, and the digit multiplexer, which it feeds. Integer conversion is sequential (shift-add-3), so one reading is in flight at a time, framed by a valid/ready handshake.

---
 rtl/temp_pkg.sv | 33 +++
 rtl/temp_bcd_conv_if.sv | 26 ++
 rtl/bcd_dabble.sv | 56 +++++
 rtl/temp_bcd_conv.sv | 134 +++++++++++++
 tb/tb_temp_bcd_conv.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/temp_pkg.sv
// Shared constants for the DS18B20 temperature-to-BCD path: FSM codes, limits,
// resolution codes and the fractional-digit lookup table.
package temp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StLoad  = 2'd1;
    localparam state_t StShift = 2'd2;
    localparam state_t StDone  = 2'd3;

    localparam logic [1:0] RES_9  = 2'd0;
    localparam logic [1:0] RES_10 = 2'd1;
    localparam logic [1:0] RES_11 = 2'd2;
    localparam logic [1:0] RES_12 = 2'd3;

    // Magnitudes in sensor LSBs: +125.0 and -55.0 degrees.
    localparam logic [15:0] POS_MAX = 16'h07D0;
    localparam logic [15:0] NEG_MAX = 16'h0370;

    // k * 0.0625 written as four BCD digits.
    localparam logic [15:0] FRAC_LUT [16] = '{
        16'h0000, 16'h0625, 16'h1250, 16'h1875,
        16'h2500, 16'h3125, 16'h3750, 16'h4375,
        16'h5000, 16'h5625, 16'h6250, 16'h6875,
        16'h7500, 16'h8125, 16'h8750, 16'h9375
    };

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/temp_bcd_conv_if.sv
// Sensor-side handshake and display-side result bundle for temp_bcd_conv.
interface temp_bcd_conv_if;

    logic [15:0] raw_in;
    logic [1:0]  res_in;
    logic        raw_vld;
    logic        in_rdy;
    logic        out_vld;
    logic        sign;
    logic [3:0]  bcd_hun;
    logic [3:0]  bcd_ten;
    logic [3:0]  bcd_one;
    logic [15:0] bcd_frac;
    logic        err;

    modport master (
        output raw_in, res_in, raw_vld,
        input  in_rdy, out_vld, sign, bcd_hun, bcd_ten, bcd_one, bcd_frac, err
    );

    modport slave (
        input  raw_in, res_in, raw_vld,
        output in_rdy, out_vld, sign, bcd_hun, bcd_ten, bcd_one, bcd_frac, err
    );

endinterface

// File: rtl/bcd_dabble.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, MSB first.
module bcd_dabble
    import temp_pkg::*;
#(
    parameter int unsigned INT_BITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [INT_BITS-1:0] bin,
    output logic                busy,
    output logic                last,
    output logic [11:0]         bcd
);

    localparam int unsigned CNT_W = $clog2(INT_BITS + 1);

    logic [11:0]         acc_q, acc_d, adj;
    logic [INT_BITS-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Counter parks at INT_BITS when idle so busy is low out of reset.
    assign busy = (cnt_q != CNT_W'(INT_BITS));
    assign last = (cnt_q == CNT_W'(INT_BITS - 1));
    assign bcd  = acc_q;

    assign adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};

    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (start) begin
            acc_d = 12'd0;
            sh_d  = bin;
            cnt_d = '0;
        end else if (busy) begin
            acc_d = (adj << 1) | {11'd0, sh_q[INT_BITS-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 12'd0;
            sh_q  <= '0;
            cnt_q <= CNT_W'(INT_BITS);
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/temp_bcd_conv.sv
// DS18B20 raw reading to sign-magnitude BCD: handshake, sign/magnitude, resolution
// masking, range check and held result registers around a sequential BCD core.
module temp_bcd_conv
    import temp_pkg::*;
#(
    parameter int unsigned INT_BITS = 7
) (
    input logic            clk,
    input logic            rst_n,
    temp_bcd_conv_if.slave bus
);

    state_t      state_q, state_d;
    logic [15:0] raw_q;
    logic [1:0]  res_q;
    logic [15:0] mag_raw, mag;
    logic        sign_c, err_c;
    logic [3:0]  frac_idx_q;
    logic        sign_q, err_q;
    logic        accept;

    logic        dab_start, dab_busy, dab_last;
    logic [11:0] dab_bcd;

    logic        out_vld_q, sign_out_q, err_out_q;
    logic [3:0]  hun_q, ten_q, one_q;
    logic [15:0] frac_q;

    assign accept = (state_q == StIdle) & bus.raw_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.raw_vld) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (dab_busy && dab_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mag_raw = raw_q[15] ? (16'd0 - raw_q) : raw_q;
        case (res_q)
            RES_9:   mag = {mag_raw[15:3], 3'b000};
            RES_10:  mag = {mag_raw[15:2], 2'b00};
            RES_11:  mag = {mag_raw[15:1], 1'b0};
            default: mag = mag_raw;
        endcase
        // Masking can turn a small negative into zero; that reads as +0.
        sign_c = raw_q[15] & (mag != 16'd0);
        err_c  = raw_q[15] ? (mag > NEG_MAX) : (mag > POS_MAX);
    end

    assign dab_start = (state_q == StLoad);

    bcd_dabble #(
        .INT_BITS (INT_BITS)
    ) u_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dab_start),
        .bin   (mag[INT_BITS+3:4]),
        .busy  (dab_busy),
        .last  (dab_last),
        .bcd   (dab_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            raw_q   <= 16'd0;
            res_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                raw_q <= bus.raw_in;
                res_q <= bus.res_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_idx_q <= 4'd0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (state_q == StLoad) begin
            frac_idx_q <= mag[3:0];
            sign_q     <= sign_c;
            err_q      <= err_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            sign_out_q <= 1'b0;
            err_out_q  <= 1'b0;
            hun_q      <= 4'd0;
            ten_q      <= 4'd0;
            one_q      <= 4'd0;
            frac_q     <= 16'd0;
        end else begin
            out_vld_q <= (state_q == StDone);
            if (state_q == StDone) begin
                err_out_q <= err_q;
                if (err_q) begin
                    sign_out_q <= 1'b0;
                    hun_q      <= 4'd0;
                    ten_q      <= 4'd0;
                    one_q      <= 4'd0;
                    frac_q     <= 16'd0;
                end else begin
                    sign_out_q <= sign_q;
                    hun_q      <= dab_bcd[11:8];
                    ten_q      <= dab_bcd[7:4];
                    one_q      <= dab_bcd[3:0];
                    frac_q     <= FRAC_LUT[frac_idx_q];
                end
            end
        end
    end

    assign bus.in_rdy   = (state_q == StIdle);
    assign bus.out_vld  = out_vld_q;
    assign bus.sign     = sign_out_q;
    assign bus.err      = err_out_q;
    assign bus.bcd_hun  = hun_q;
    assign bus.bcd_ten  = ten_q;
    assign bus.bcd_one  = one_q;
    assign bus.bcd_frac = frac_q;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Scoreboard bench for temp_bcd_conv: driver pushes reference results, monitor pops on out_vld.
module tb_temp_bcd_conv;

    typedef struct packed {
        logic        sign;
        logic [3:0]  hun;
        logic [3:0]  ten;
        logic [3:0]  one;
        logic [15:0] frac;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_acc = 0;

    res_t exp_q[$];
    int   acc_q[$];
    res_t last_out = '0;
    logic prev_vld = 1'b0;

    temp_bcd_conv_if bus ();

    temp_bcd_conv #(
        .INT_BITS (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: temperature in 1/16 degree units, truncated toward zero to the resolution step.
    function automatic res_t model(input logic [15:0] raw, input logic [1:0] res);
        res_t r;
        bit   neg;
        int   m, step, ip, fr;
        neg  = raw[15];
        m    = neg ? 65536 - int'(raw) : int'(raw);
        step = 1 << (3 - int'(res));
        m    = m - (m % step);
        r.err  = neg ? (m > 55 * 16) : (m > 125 * 16);
        r.sign = neg && (m != 0);
        ip = m / 16;
        fr = (m % 16) * 625;
        r.hun  = 4'(ip / 100);
        r.ten  = 4'((ip / 10) % 10);
        r.one  = 4'(ip % 10);
        r.frac = {4'(fr / 1000), 4'((fr / 100) % 10), 4'((fr / 10) % 10), 4'(fr % 10)};
        if (r.err) begin
            r.sign = 1'b0;
            r.hun  = 4'd0;
            r.ten  = 4'd0;
            r.one  = 4'd0;
            r.frac = 16'd0;
        end
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.sign, bus.bcd_hun, bus.bcd_ten, bus.bcd_one, bus.bcd_frac, bus.err};
    endfunction

    task automatic send(input logic [15:0] raw, input logic [1:0] res, input bit keep_vld);
        bit rdy;
        int waited;
        @(negedge clk);
        bus.raw_in  = raw;
        bus.res_in  = res;
        bus.raw_vld = 1'b1;
        waited = 0;
        forever begin
            rdy = bus.in_rdy;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: raw %h never accepted, in_rdy=%b required 1",
                         raw, bus.in_rdy);
                bus.raw_vld = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back(model(raw, res));
        acc_q.push_back(cyc);
        last_acc = cyc;
        if (!keep_vld) bus.raw_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: result and latency on out_vld, single-cycle pulse, outputs held otherwise.
    initial begin
        res_t act, e;
        int   a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
                continue;
            end
            act = observed();
            if (prev_vld) begin
                n_tests++;
                if (bus.out_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vld_pulse: out_vld=%b one cycle after pulse, required 0",
                             bus.out_vld);
                end
            end
            if (bus.out_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_vld: out_vld=1 at cycle %0d with nothing pending, required 0",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    n_tests += 2;
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL result: got %h expected %h (sign,hun,ten,one,frac,err)",
                                 act, e);
                    end
                    if (cyc != a + 9) begin
                        n_fail++;
                        $display("FAIL latency: got %0d clocks expected 9", cyc - a);
                    end
                    last_out = e;
                end
            end else begin
                n_tests++;
                if (act !== last_out) begin
                    n_fail++;
                    $display("FAIL hold: got %h expected %h", act, last_out);
                end
            end
            prev_vld = bus.out_vld;
        end
    end

    initial begin
        int e1;
        bus.raw_in  = 16'd0;
        bus.res_in  = 2'd0;
        bus.raw_vld = 1'b0;

        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.in_rdy, bus.out_vld, observed()} !== {2'b10, 30'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b out=%h expected rdy=1 vld=0 out=0",
                     bus.in_rdy, bus.out_vld, observed());
        end
        rst_n = 1'b1;
        @(negedge clk);

        send(16'h0191, 2'd3, 0);
        send(16'hFF5E, 2'd3, 0);
        send(16'hFC90, 2'd3, 0);
        send(16'h0191, 2'd0, 0);
        send(16'hFFFF, 2'd0, 0);
        send(16'h07D0, 2'd3, 0);
        send(16'h07E0, 2'd3, 0);
        send(16'hFC80, 2'd3, 0);
        send(16'h8000, 2'd2, 0);
        wait_drain();

        // A request while busy must be ignored entirely.
        send(16'h0191, 2'd3, 0);
        e1 = last_acc;
        while (cyc < e1 + 2) @(posedge clk);
        @(negedge clk);
        bus.raw_in  = 16'h0050;
        bus.res_in  = 2'd3;
        bus.raw_vld = 1'b1;
        @(negedge clk);
        bus.raw_vld = 1'b0;
        wait_drain();

        // raw_vld held high across two readings.
        send(16'h0250, 2'd3, 1);
        e1 = last_acc;
        send(16'hFE6F, 2'd1, 0);
        n_tests++;
        if (last_acc != e1 + 10) begin
            n_fail++;
            $display("FAIL back_to_back: second accept %0d clocks after first, required 10",
                     last_acc - e1);
        end
        wait_drain();

        // Reset in the middle of a conversion.
        send(16'h07D0, 2'd3, 0);
        e1 = last_acc;
        while (cyc < e1 + 5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_rdy, bus.out_vld, observed()} !== {2'b10, 30'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b out=%h expected rdy=1 vld=0 out=0",
                     bus.in_rdy, bus.out_vld, observed());
        end
        exp_q.delete();
        acc_q.delete();
        last_out = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdy_after_reset: got %b required 1", bus.in_rdy);
        end
        repeat (15) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [15:0] raw;
            bit          keep;
            if ($urandom_range(0, 3) == 0) raw = 16'($urandom);
            else raw = 16'(int'($urandom_range(0, 2000 + 880)) - 880);
            keep = ($urandom_range(0, 3) == 0);
            send(raw, 2'($urandom_range(0, 3)), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.raw_vld = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
